// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single-port 1-cycle-latency memory; grant is same-cycle combinational, response N+1.
// Data normally wins; a fetch that has lost MAX_WAIT consecutive cycles wins next. Losers simply hold req until granted.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [31:0]           i_rdata,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_wstrb,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,

    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0] r_wait_cnt;
    logic       r_i_owner;
    logic       r_d_owner;
    logic       w_fetch_wins;

    // Fetch wins when alone, or when it has been starved for MAX_WAIT cycles.
    assign w_fetch_wins = i_req && (!d_req || (r_wait_cnt == LP_MAX_WAIT));

    assign i_gnt     = !rst && w_fetch_wins;
    assign d_gnt     = !rst && d_req && !w_fetch_wins;

    assign mem_en    = i_gnt || d_gnt;
    assign mem_we    = (d_gnt && d_we) ? d_wstrb : 4'b0000;
    assign mem_addr  = d_gnt ? d_addr : i_addr;
    assign mem_wdata = d_gnt ? d_wdata : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 4'd0;
            r_i_owner  <= 1'b0;
            r_d_owner  <= 1'b0;
        end else begin
            r_i_owner <= i_gnt;
            r_d_owner <= d_gnt;
            if (!i_req || i_gnt) begin
                r_wait_cnt <= 4'd0;
            end else if (r_wait_cnt != LP_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end
        end
    end

    // Gated by rst so a response already registered when reset arrives is never seen.
    assign i_rvalid = r_i_owner && !rst;
    assign d_rvalid = r_d_owner && !rst;
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule
